// File: rtl/fir_compute_responder.sv
// FIR compute responder: latches argument pointers from the register-file
// write port and, on fir_start, computes one output sample
//   y = sum_{k=0}^{NUM_TAPS-1} c[k] * x[n-k]
// through a 1-cycle-latency read port, writes y back and pulses fir_done.
// Every tap costs exactly three cycles (READ_X, READ_C, MAC), so latency is
// fixed even for zero-padded taps.
module fir_compute_responder #(
  parameter int          NUM_TAPS   = 8,
  parameter logic [31:0] INPUT_BASE = 32'h0000_0000,
  parameter int          SHIFT      = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fir_rf_we,
  input  logic [4:0]  fir_rf_waddr,
  input  logic [31:0] fir_rf_wdata,
  input  logic        fir_start,
  output logic        fir_done,
  output logic        busy,
  output logic        busy_err,
  output logic        mem_re,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_X = 3'd1,
    S_READ_C = 3'd2,
    S_MAC    = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] x_q, x_d;
  logic        pad_q, pad_d;
  logic [31:0] x_ptr_q, x_ptr_d;
  logic [31:0] c_ptr_q, c_ptr_d;
  logic [31:0] y_ptr_q, y_ptr_d;
  logic [31:0] xw_q, xw_d;
  logic [31:0] cw_q, cw_d;
  logic [31:0] yw_q, yw_d;
  logic        fir_done_q, fir_done_d;
  logic        busy_q, busy_d;
  logic        busy_err_q, busy_err_d;
  logic        mem_re_q, mem_re_d;
  logic [31:0] mem_raddr_q, mem_raddr_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_waddr_q, mem_waddr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Datapath helpers: sign-extended operands, product and next accumulator
  logic [63:0] x_ext_s, c_ext_s, prod_s, acc_next_s;
  logic signed [63:0] acc_sgn_s;
  // Sample-read request for the tap about to enter READ_X
  logic        issue_x_s;
  logic [31:0] x_addr_s;
  logic [32:0] base_diff_s;

  // Next-state, datapath and registered-output logic for the whole responder
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    x_d         = x_q;
    pad_d       = pad_q;
    xw_d        = xw_q;
    cw_d        = cw_q;
    yw_d        = yw_q;
    fir_done_d  = 1'b0;
    mem_re_d    = 1'b0;
    mem_raddr_d = 32'h0000_0000;
    mem_we_d    = 1'b0;
    mem_waddr_d = 32'h0000_0000;
    mem_wdata_d = 32'h0000_0000;
    issue_x_s   = 1'b0;
    x_addr_s    = 32'h0000_0000;

    // Argument registers are writable in every state.
    if (fir_rf_we && (fir_rf_waddr == 5'd10)) begin
      x_ptr_d = fir_rf_wdata;
    end else begin
      x_ptr_d = x_ptr_q;
    end
    if (fir_rf_we && (fir_rf_waddr == 5'd11)) begin
      c_ptr_d = fir_rf_wdata;
    end else begin
      c_ptr_d = c_ptr_q;
    end
    if (fir_rf_we && (fir_rf_waddr == 5'd12)) begin
      y_ptr_d = fir_rf_wdata;
    end else begin
      y_ptr_d = y_ptr_q;
    end

    // A start outside IDLE is dropped but remembered until reset.
    busy_err_d = busy_err_q | (fir_start & (state_q != S_IDLE));

    x_ext_s    = {{32{x_q[31]}}, x_q};
    c_ext_s    = {{32{mem_rdata[31]}}, mem_rdata};
    prod_s     = x_ext_s * c_ext_s;
    acc_next_s = acc_q + prod_s;
    acc_sgn_s  = acc_next_s;

    case (state_q)
      S_IDLE: begin
        if (fir_start) begin
          // Snapshot uses the _d values so a same-cycle write is bypassed.
          xw_d      = x_ptr_d;
          cw_d      = c_ptr_d;
          yw_d      = y_ptr_d;
          k_d       = 6'd0;
          acc_d     = 64'h0;
          state_d   = S_READ_X;
          issue_x_s = 1'b1;
          x_addr_s  = x_ptr_d;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ_X: begin
        mem_re_d    = 1'b1;
        mem_raddr_d = cw_q + 32'({k_q, 2'b00});
        state_d     = S_READ_C;
      end
      S_READ_C: begin
        if (pad_q) begin
          x_d = 32'h0000_0000;
        end else begin
          x_d = mem_rdata;
        end
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_next_s;
        if (k_q == 6'(NUM_TAPS - 1)) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = yw_q;
          mem_wdata_d = 32'(acc_sgn_s >>> SHIFT);
          state_d     = S_WRITE;
        end else begin
          k_d       = k_q + 6'd1;
          issue_x_s = 1'b1;
          x_addr_s  = xw_q - 32'({k_q + 6'd1, 2'b00});
          state_d   = S_READ_X;
        end
      end
      S_WRITE: begin
        fir_done_d = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sample reads below INPUT_BASE are suppressed and read as zero later;
    // the borrow of an unsigned subtract gives the below-base decision.
    base_diff_s = {1'b0, x_addr_s} - {1'b0, INPUT_BASE};
    if (issue_x_s) begin
      pad_d = base_diff_s[32];
      if (base_diff_s[32]) begin
        mem_re_d    = 1'b0;
        mem_raddr_d = 32'h0000_0000;
      end else begin
        mem_re_d    = 1'b1;
        mem_raddr_d = x_addr_s;
      end
    end else begin
      pad_d = pad_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, working registers and registered outputs; async reset aborts a run
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      k_q         <= 6'd0;
      acc_q       <= 64'h0;
      x_q         <= 32'h0000_0000;
      pad_q       <= 1'b0;
      x_ptr_q     <= 32'h0000_0000;
      c_ptr_q     <= 32'h0000_0000;
      y_ptr_q     <= 32'h0000_0000;
      xw_q        <= 32'h0000_0000;
      cw_q        <= 32'h0000_0000;
      yw_q        <= 32'h0000_0000;
      fir_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      busy_err_q  <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= 32'h0000_0000;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      pad_q       <= pad_d;
      x_ptr_q     <= x_ptr_d;
      c_ptr_q     <= c_ptr_d;
      y_ptr_q     <= y_ptr_d;
      xw_q        <= xw_d;
      cw_q        <= cw_d;
      yw_q        <= yw_d;
      fir_done_q  <= fir_done_d;
      busy_q      <= busy_d;
      busy_err_q  <= busy_err_d;
      mem_re_q    <= mem_re_d;
      mem_raddr_q <= mem_raddr_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign fir_done  = fir_done_q;
  assign busy      = busy_q;
  assign busy_err  = busy_err_q;
  assign mem_re    = mem_re_q;
  assign mem_raddr = mem_raddr_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fir_compute_responder.sv
// Bench for fir_compute_responder: a behavioural model predicts every output
// on every cycle from the run schedule (3 cycles per tap, then write, then
// done); directed runs pin the model with hand-computed values, and a random
// phase exercises argument writes, overlapping starts and padding.
module tb_fir_compute_responder;

  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam int          SH     = 2;
  localparam int          RUNLEN = 3 * N + 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        fir_rf_we = 1'b0;
  logic [4:0]  fir_rf_waddr = 5'd0;
  logic [31:0] fir_rf_wdata = 32'h0;
  logic        fir_start = 1'b0;
  logic        fir_done, busy, busy_err, mem_re, mem_we;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic chk_en = 1'b0;
  int low_rd = 0;

  always #5 clock = ~clock;

  fir_compute_responder #(.NUM_TAPS(N), .INPUT_BASE(BASE), .SHIFT(SH)) dut (
    .clock(clock), .reset_n(reset_n),
    .fir_rf_we(fir_rf_we), .fir_rf_waddr(fir_rf_waddr), .fir_rf_wdata(fir_rf_wdata),
    .fir_start(fir_start), .fir_done(fir_done), .busy(busy), .busy_err(busy_err),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // ---------------- memory ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= mem_read(mem_raddr);
    else        mem_rdata <= $urandom;
    if (mem_we) mem[mem_waddr] = mem_wdata;
  end

  // ---------------- behavioural model ----------------
  int          j = 0;            // 0 = idle, else position within the run
  logic [31:0] m_x = 0, m_c = 0, m_y = 0;
  logic [31:0] s_x = 0, s_c = 0, s_y = 0, s_val = 0;
  logic        m_berr = 1'b0;

  function automatic logic [31:0] fir_eval(input logic [31:0] xw, input logic [31:0] cw);
    longint acc = 0;
    logic [31:0] a, xv, cv;
    for (int k = 0; k < N; k++) begin
      a  = xw - 32'(4 * k);
      xv = (a >= BASE) ? mem_read(a) : 32'h0;
      cv = mem_read(cw + 32'(4 * k));
      acc += longint'(signed'(xv)) * longint'(signed'(cv));
    end
    return 32'(acc >>> SH);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      j = 0; m_x = 0; m_c = 0; m_y = 0; m_berr = 1'b0;
    end else begin
      if (j != 0) begin
        if (fir_start) m_berr = 1'b1;
        j = (j == RUNLEN) ? 0 : j + 1;
      end else if (fir_start) begin
        s_x   = (fir_rf_we && fir_rf_waddr == 5'd10) ? fir_rf_wdata : m_x;
        s_c   = (fir_rf_we && fir_rf_waddr == 5'd11) ? fir_rf_wdata : m_c;
        s_y   = (fir_rf_we && fir_rf_waddr == 5'd12) ? fir_rf_wdata : m_y;
        s_val = fir_eval(s_x, s_c);
        j = 1;
      end
      if (fir_rf_we) begin
        case (fir_rf_waddr)
          5'd10: m_x = fir_rf_wdata;
          5'd11: m_c = fir_rf_wdata;
          5'd12: m_y = fir_rf_wdata;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [100:0] exp_vec();
    logic b = 0, d = 0, re = 0, we = 0;
    logic [31:0] ra = 0, wa = 0, wd = 0, a;
    int k, ph;
    if (j != 0) begin
      b = 1'b1;
      if (j <= 3 * N) begin
        k  = (j - 1) / 3;
        ph = (j - 1) % 3;
        if (ph == 0) begin
          a = s_x - 32'(4 * k);
          if (a >= BASE) begin re = 1'b1; ra = a; end
        end else if (ph == 1) begin
          re = 1'b1; ra = s_c + 32'(4 * k);
        end
      end else if (j == 3 * N + 1) begin
        we = 1'b1; wa = s_y; wd = s_val;
      end else begin
        d = 1'b1;
      end
    end
    return {b, m_berr, d, re, ra, we, wa, wd};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    logic [100:0] got, expv;
    if (chk_en) begin
      got  = {busy, busy_err, fir_done, mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata};
      expv = exp_vec();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL cycle_compare t=%0t j=%0d actual=%h expected=%h", $time, j, got, expv);
      end
      if (mem_re && mem_raddr < BASE) low_rd++;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_arg(input logic [4:0] idx, input logic [31:0] val);
    fir_rf_we = 1'b1; fir_rf_waddr = idx; fir_rf_wdata = val;
    tick();
    fir_rf_we = 1'b0;
  endtask

  task automatic start_run(output int unsigned sc);
    fir_start = 1'b1;
    tick();
    fir_start = 1'b0;
    sc = cyc;
  endtask

  // Cycle indices are relative to the start cycle (cycle 0).
  task automatic wait_done(input int unsigned sc, output int we_c, output int done_c,
                           output logic [31:0] we_a);
    we_c = -1; done_c = -1; we_a = 32'h0;
    for (int i = 0; i < 60; i++) begin
      if (mem_we) begin we_c = int'(cyc - sc) + 1; we_a = mem_waddr; end
      if (fir_done) begin done_c = int'(cyc - sc) + 1; break; end
      tick();
    end
    if (done_c < 0) check("done_timeout", 64'd0, 64'd1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned sc;
    int we_c, done_c, cnt;
    logic [31:0] we_a;
    int sel;

    for (int i = 0; i < 8; i++) mem[BASE + 32'(4 * i)] = 32'(i + 1);
    mem[32'h0000_00FC] = 32'd100;
    mem[32'h0000_00F8] = 32'd200;
    for (int k = 0; k < N; k++) mem[32'h0000_0200 + 32'(4 * k)] = 32'(k + 1);

    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    check("reset_outputs", 64'({busy, busy_err, fir_done, mem_re, mem_we, mem_raddr}), 64'h0);
    tick();

    // Basic run: y = 4*1+3*2+2*3+1*4 = 20, >>>2 = 5
    wr_arg(5'd10, 32'h0000_010C);
    wr_arg(5'd11, 32'h0000_0200);
    wr_arg(5'd12, 32'h0000_0800);
    start_run(sc);
    wait_done(sc, we_c, done_c, we_a);
    check("basic_we_cycle", 64'(we_c), 64'd13);
    check("basic_done_cycle", 64'(done_c), 64'd14);
    check("basic_waddr", 64'(we_a), 64'h800);
    check("basic_y", 64'(mem_read(32'h800)), 64'd5);

    // Padded taps: 2*1 + 1*2 + 0 + 0 = 4, >>>2 = 1
    wr_arg(5'd10, 32'h0000_0104);
    wr_arg(5'd12, 32'h0000_0804);
    start_run(sc);
    wait_done(sc, we_c, done_c, we_a);
    check("pad_done_cycle", 64'(done_c), 64'd14);
    check("pad_y", 64'(mem_read(32'h804)), 64'd1);

    // Negative samples: 4*(-3*5) = -60, >>>2 = -15
    for (int k = 0; k < N; k++) begin
      mem[32'h0000_0300 + 32'(4 * k)] = 32'hFFFF_FFFD;
      mem[32'h0000_0400 + 32'(4 * k)] = 32'd5;
      mem[32'h0000_0600 + 32'(4 * k)] = 32'h7FFF_FFFF;
    end
    mem[32'h0000_0500] = 32'h0; mem[32'h0000_0504] = 32'h0;
    mem[32'h0000_0508] = 32'h7FFF_FFFF; mem[32'h0000_050C] = 32'h7FFF_FFFF;
    wr_arg(5'd10, 32'h0000_030C);
    wr_arg(5'd11, 32'h0000_0400);
    wr_arg(5'd12, 32'h0000_0808);
    start_run(sc);
    wait_done(sc, we_c, done_c, we_a);
    check("neg_y", 64'(mem_read(32'h808)), 64'hFFFF_FFF1);

    // 64-bit accumulation: 2*0x3FFFFFFF00000001 = 0x7FFFFFFE00000002, >>>2 -> low word 0x80000000
    wr_arg(5'd10, 32'h0000_050C);
    wr_arg(5'd11, 32'h0000_0600);
    wr_arg(5'd12, 32'h0000_080C);
    start_run(sc);
    wait_done(sc, we_c, done_c, we_a);
    check("wide_acc_y", 64'(mem_read(32'h80C)), 64'h8000_0000);

    // Start while busy at cycle 5: ignored, sticky error
    wr_arg(5'd10, 32'h0000_010C);
    wr_arg(5'd11, 32'h0000_0200);
    wr_arg(5'd12, 32'h0000_0810);
    check("busy_err_before", 64'(busy_err), 64'd0);
    start_run(sc);
    tick(); tick(); tick(); tick();
    fir_start = 1'b1;
    tick();
    fir_start = 1'b0;
    wait_done(sc, we_c, done_c, we_a);
    check("overlap_done_cycle", 64'(done_c), 64'd14);
    check("overlap_y", 64'(mem_read(32'h810)), 64'd5);
    check("overlap_busy_err", 64'(busy_err), 64'd1);

    // Reset in the first MAC cycle aborts the run
    mem[32'h0000_0814] = 32'hDEAD_BEEF;
    wr_arg(5'd12, 32'h0000_0814);
    start_run(sc);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("abort_outputs", 64'({busy, busy_err, fir_done, mem_re, mem_we, mem_raddr}), 64'h0);
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_we || fir_done || busy) cnt++;
      tick();
    end
    check("abort_quiet", 64'(cnt), 64'd0);
    check("abort_mem", 64'(mem_read(32'h814)), 64'hDEAD_BEEF);

    // Same-cycle x10 write is bypassed; mid-run x12 write affects only the next run
    wr_arg(5'd11, 32'h0000_0200);
    wr_arg(5'd12, 32'h0000_0818);
    fir_rf_we = 1'b1; fir_rf_waddr = 5'd10; fir_rf_wdata = 32'h0000_0108;
    fir_start = 1'b1;
    tick();
    fir_start = 1'b0; fir_rf_we = 1'b0;
    sc = cyc;
    check("bypass_raddr", 64'({mem_re, mem_raddr}), 64'h1_0000_0108);
    wr_arg(5'd12, 32'h0000_0900);
    wait_done(sc, we_c, done_c, we_a);
    check("midrun_waddr", 64'(we_a), 64'h818);
    check("bypass_y", 64'(mem_read(32'h818)), 64'd2);
    check("midrun_untouched", 64'(mem_read(32'h900)), 64'd0);

    // Random phase
    for (int a = 0; a < 24; a++) mem[32'h0000_00E0 + 32'(4 * a)] = $urandom;
    for (int a = 0; a < 16; a++) mem[32'h0000_0200 + 32'(4 * a)] = $urandom;
    for (int i = 0; i < 1500; i++) begin
      fir_start = ($urandom_range(0, 7) == 0);
      fir_rf_we = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 3);
      fir_rf_waddr = (sel == 3) ? 5'($urandom) : 5'(10 + sel);
      case (fir_rf_waddr)
        5'd10:   fir_rf_wdata = 32'h0000_00F0 + 32'(4 * $urandom_range(0, 15));
        5'd11:   fir_rf_wdata = 32'h0000_0200 + 32'(4 * $urandom_range(0, 7));
        5'd12:   fir_rf_wdata = 32'h0000_0A00 + 32'(4 * $urandom_range(0, 7));
        default: fir_rf_wdata = $urandom;
      endcase
      tick();
    end
    fir_start = 1'b0; fir_rf_we = 1'b0;
    for (int i = 0; i < RUNLEN + 4; i++) tick();

    check("no_read_below_base", 64'(low_rd), 64'd0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
